uart_tx_frame: RTL and testbench

Serializes the 8-bit edge count produced each 0.25 s measurement window onto the UART line as an 8N1 (or 8N2) frame. Sits downstream of the edge counter: the window-end strobe and the count byte drive `load`/`data_in`, and `tx` goes to the board's UART pin. A one-byte holding register double-buffers the shift register so a new count can be accepted while the previous frame is still on the wire.

---
 rtl/uart_tx_frame.sv | 145 ++++++++++++++
 tb/tb_uart_tx_frame.sv | 355 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_frame.sv
// UART transmitter: one-byte holding register feeding an 8N1/8N2 shift register.
// A new byte can be accepted while the previous frame is still being sent.
module uart_tx_frame #(
    parameter int unsigned BAUD_DIV  = 434,
    parameter int unsigned STOP_BITS = 1
) (
    input  logic       clk_in,
    input  logic       reset,
    input  logic       load,
    input  logic [7:0] data_in,
    input  logic       clr_ovr,
    output logic       tx,
    output logic       busy,
    output logic       overrun
);

    localparam int unsigned CNT_W = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
    localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(BAUD_DIV - 1);
    localparam logic [2:0] STOP_LAST = 3'(STOP_BITS - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } state_t;

    state_t           state, state_n;
    logic [CNT_W-1:0] baud_cnt, baud_cnt_n;
    logic [2:0]       bit_idx, bit_idx_n;
    logic [7:0]       shift, shift_n;
    logic [7:0]       hold, hold_n;
    logic             pending, pending_n;
    logic             overrun_n;
    logic             tx_n;
    logic             busy_n;
    logic             bit_end;
    logic             take;
    logic             accept;
    logic             drop;

    // State and datapath registers
    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            state    <= S_IDLE;
            baud_cnt <= '0;
            bit_idx  <= '0;
            shift    <= '0;
            hold     <= '0;
            pending  <= 1'b0;
            overrun  <= 1'b0;
            tx       <= 1'b1;
            busy     <= 1'b0;
        end else begin
            state    <= state_n;
            baud_cnt <= baud_cnt_n;
            bit_idx  <= bit_idx_n;
            shift    <= shift_n;
            hold     <= hold_n;
            pending  <= pending_n;
            overrun  <= overrun_n;
            tx       <= tx_n;
            busy     <= busy_n;
        end
    end

    // Next-state, holding-register handshake and registered-output values
    always_comb begin
        state_n    = state;
        baud_cnt_n = baud_cnt + CNT_W'(1);
        bit_idx_n  = bit_idx;
        shift_n    = shift;
        take       = 1'b0;
        bit_end    = (baud_cnt == BAUD_LAST);

        case (state)
            S_IDLE: begin
                baud_cnt_n = '0;
                bit_idx_n  = '0;
                if (pending) begin
                    take    = 1'b1;
                    shift_n = hold;
                    state_n = S_START;
                end
            end
            S_START: begin
                if (bit_end) begin
                    baud_cnt_n = '0;
                    bit_idx_n  = '0;
                    state_n    = S_DATA;
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    baud_cnt_n = '0;
                    shift_n    = {1'b0, shift[7:1]};
                    if (bit_idx == 3'd7) begin
                        bit_idx_n = '0;
                        state_n   = S_STOP;
                    end else begin
                        bit_idx_n = bit_idx + 3'd1;
                    end
                end
            end
            S_STOP: begin
                if (bit_end) begin
                    baud_cnt_n = '0;
                    if (bit_idx == STOP_LAST) begin
                        bit_idx_n = '0;
                        // Chain straight into the next start bit when a byte is waiting
                        if (pending) begin
                            take    = 1'b1;
                            shift_n = hold;
                            state_n = S_START;
                        end else begin
                            state_n = S_IDLE;
                        end
                    end else begin
                        bit_idx_n = bit_idx + 3'd1;
                    end
                end
            end
            default: begin
                state_n    = S_IDLE;
                baud_cnt_n = '0;
                bit_idx_n  = '0;
            end
        endcase

        accept = load & (~pending | take);
        drop   = load & pending & ~take;

        hold_n    = accept ? data_in : hold;
        pending_n = accept ? 1'b1 : (take ? 1'b0 : pending);
        overrun_n = drop ? 1'b1 : (clr_ovr ? 1'b0 : overrun);

        case (state_n)
            S_START: tx_n = 1'b0;
            S_DATA:  tx_n = shift_n[0];
            default: tx_n = 1'b1;
        endcase
        busy_n = pending_n | (state_n != S_IDLE);
    end

endmodule

// File: tb/tb_uart_tx_frame.sv
// Self-checking bench for uart_tx_frame: a frame-timeline reference model is
// compared against tx/busy/overrun every cycle, plus directed waveform checks.
module tb_uart_tx_frame;

    localparam int BD = 4;
    localparam int SB = 1;
    localparam int FL = (9 + SB) * BD;

    logic       clk_in;
    logic       reset;
    logic       load, clr_ovr;
    logic [7:0] data_in;
    logic       tx, busy, overrun;
    logic       load2, clr2;
    logic [7:0] data2;
    logic       tx2, busy2, ovr2;

    int checks;
    int errors;

    uart_tx_frame #(.BAUD_DIV(BD), .STOP_BITS(SB)) dut (
        .clk_in (clk_in),
        .reset  (reset),
        .load   (load),
        .data_in(data_in),
        .clr_ovr(clr_ovr),
        .tx     (tx),
        .busy   (busy),
        .overrun(overrun)
    );

    uart_tx_frame #(.BAUD_DIV(2), .STOP_BITS(2)) dut2 (
        .clk_in (clk_in),
        .reset  (reset),
        .load   (load2),
        .data_in(data2),
        .clr_ovr(clr2),
        .tx     (tx2),
        .busy   (busy2),
        .overrun(ovr2)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    // Reference model: a frame is a time window starting at the transfer edge.
    int         t;
    logic       m_in;
    int         m_t0;
    logic [7:0] m_byte;
    logic       m_pend;
    logic [7:0] m_hold;
    logic       m_ovr;

    function automatic void model_reset();
        m_in   = 1'b0;
        m_pend = 1'b0;
        m_ovr  = 1'b0;
        m_hold = 8'h00;
        m_byte = 8'h00;
        m_t0   = 0;
    endfunction

    function automatic void model_edge(input logic ld, input logic [7:0] d, input logic clr);
        logic done, free, take, acc, ovf;
        done = m_in && (t == m_t0 + FL);
        free = !m_in || done;
        take = free && m_pend;
        if (take) begin
            m_in   = 1'b1;
            m_t0   = t;
            m_byte = m_hold;
        end else if (done) begin
            m_in = 1'b0;
        end
        acc = ld && (!m_pend || take);
        ovf = ld && m_pend && !take;
        if (acc) begin
            m_pend = 1'b1;
            m_hold = d;
        end else if (take) begin
            m_pend = 1'b0;
        end
        if (ovf) m_ovr = 1'b1;
        else if (clr) m_ovr = 1'b0;
    endfunction

    function automatic logic exp_tx();
        int slot;
        if (!m_in) return 1'b1;
        slot = (t - m_t0) / BD;
        if (slot == 0) return 1'b0;
        if (slot <= 8) return m_byte[slot-1];
        return 1'b1;
    endfunction

    function automatic logic exp_busy();
        return m_pend || m_in;
    endfunction

    task automatic tick(input logic ld, input logic [7:0] d, input logic clr);
        load    = ld;
        data_in = d;
        clr_ovr = clr;
        @(posedge clk_in);
        t++;
        model_edge(ld, d, clr);
        #1;
        load    = 1'b0;
        clr_ovr = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        load = 1'b0; clr_ovr = 1'b0; data_in = 8'h00;
        load2 = 1'b0; clr2 = 1'b0; data2 = 8'h00;
        model_reset();
        t = 0;
        repeat (2) @(posedge clk_in);
        #1;
        reset = 1'b1;
        checks++;
        if (tx !== 1'b1 || busy !== 1'b0 || overrun !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: tx=%b busy=%b ovr=%b required 1 0 0", tx, busy, overrun);
        end
        checks++;
        if (tx2 !== 1'b1 || busy2 !== 1'b0 || ovr2 !== 1'b0) begin
            errors++;
            $display("FAIL reset_state2: tx=%b busy=%b ovr=%b required 1 0 0", tx2, busy2, ovr2);
        end
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 200 && (m_in || m_pend); i++) begin
            tick(1'b0, 8'h00, 1'b0);
            checks++;
            if (tx !== exp_tx() || busy !== exp_busy() || overrun !== m_ovr) begin
                errors++;
                $display("FAIL %s_drain t=%0d: tx=%b busy=%b ovr=%b required %b %b %b",
                         name, t, tx, busy, overrun, exp_tx(), exp_busy(), m_ovr);
            end
        end
        tick(1'b0, 8'h00, 1'b0);
        checks++;
        if (busy !== 1'b0 || tx !== 1'b1) begin
            errors++;
            $display("FAIL %s_idle: tx=%b busy=%b required 1 0", name, tx, busy);
        end
    endtask

    task automatic test_single();
        logic [9:0] pat;
        pat = {1'b1, 8'hA5, 1'b0};
        tick(1'b1, 8'hA5, 1'b0);
        checks++;
        if (tx !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL single_e0: tx=%b busy=%b required 1 1", tx, busy);
        end
        for (int k = 1; k <= FL; k++) begin
            tick(1'b0, 8'h00, 1'b0);
            checks++;
            if (tx !== pat[(k-1)/BD] || busy !== 1'b1) begin
                errors++;
                $display("FAIL single_bit k=%0d: tx=%b busy=%b required %b 1",
                         k, tx, busy, pat[(k-1)/BD]);
            end
        end
        tick(1'b0, 8'h00, 1'b0);
        checks++;
        if (tx !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL single_end: tx=%b busy=%b required 1 0", tx, busy);
        end
    endtask

    task automatic test_back_to_back();
        int gap;
        logic seen_stop;
        gap = 0;
        seen_stop = 1'b0;
        for (int k = 0; k < 2 * FL + 8; k++) begin
            if (k == 0) tick(1'b1, 8'h55, 1'b0);
            else if (k == 10) tick(1'b1, 8'h0F, 1'b0);
            else tick(1'b0, 8'h00, 1'b0);
            checks++;
            if (tx !== exp_tx() || busy !== exp_busy() || overrun !== m_ovr) begin
                errors++;
                $display("FAIL b2b t=%0d: tx=%b busy=%b ovr=%b required %b %b %b",
                         t, tx, busy, overrun, exp_tx(), exp_busy(), m_ovr);
            end
            if (k >= 1 && k <= 2 * FL && busy !== 1'b1) gap++;
        end
        checks++;
        if (gap != 0 || overrun !== 1'b0) begin
            errors++;
            $display("FAIL b2b_gap: idle_cycles=%0d ovr=%b required 0 0", gap, overrun);
        end
        drain("b2b");
    endtask

    task automatic test_overrun();
        logic [7:0] seq [3];
        seq = '{8'h01, 8'h02, 8'h03};
        for (int k = 0; k < 3; k++) begin
            tick(1'b1, seq[k], 1'b0);
            checks++;
            if (overrun !== (k == 2)) begin
                errors++;
                $display("FAIL ovr_set k=%0d: ovr=%b required %b", k, overrun, (k == 2));
            end
        end
        drain("ovr");
        checks++;
        if (overrun !== 1'b1) begin
            errors++;
            $display("FAIL ovr_sticky: ovr=%b required 1", overrun);
        end
        tick(1'b0, 8'h00, 1'b1);
        checks++;
        if (overrun !== 1'b0) begin
            errors++;
            $display("FAIL ovr_clear: ovr=%b required 0", overrun);
        end
        tick(1'b1, 8'h11, 1'b0);
        tick(1'b1, 8'h22, 1'b0);
        tick(1'b1, 8'h33, 1'b1);
        checks++;
        if (overrun !== 1'b1) begin
            errors++;
            $display("FAIL ovr_set_wins: ovr=%b required 1", overrun);
        end
        tick(1'b0, 8'h00, 1'b1);
        drain("ovr2");
    endtask

    task automatic test_stop_edge();
        for (int k = 0; k < 3 * FL + 6; k++) begin
            if (k == 0) tick(1'b1, 8'h5A, 1'b0);
            else if (k == 2) tick(1'b1, 8'hC3, 1'b0);
            else if (k == FL + 1) tick(1'b1, 8'h99, 1'b0);
            else tick(1'b0, 8'h00, 1'b0);
            checks++;
            if (tx !== exp_tx() || busy !== exp_busy() || overrun !== m_ovr) begin
                errors++;
                $display("FAIL stop_edge t=%0d: tx=%b busy=%b ovr=%b required %b %b %b",
                         t, tx, busy, overrun, exp_tx(), exp_busy(), m_ovr);
            end
        end
        checks++;
        if (overrun !== 1'b0) begin
            errors++;
            $display("FAIL stop_edge_ovr: ovr=%b required 0", overrun);
        end
        drain("stop_edge");
    endtask

    task automatic test_reset_mid();
        tick(1'b1, 8'hFF, 1'b0);
        tick(1'b1, 8'h00, 1'b0);
        tick(1'b1, 8'h00, 1'b0);
        repeat (16) tick(1'b0, 8'h00, 1'b0);
        checks++;
        if (overrun !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL mid_pre: ovr=%b busy=%b required 1 1", overrun, busy);
        end
        reset = 1'b0;
        #1;
        checks++;
        if (tx !== 1'b1 || busy !== 1'b0 || overrun !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset: tx=%b busy=%b ovr=%b required 1 0 0", tx, busy, overrun);
        end
        model_reset();
        @(posedge clk_in);
        #1;
        reset = 1'b1;
        for (int k = 0; k < FL + 4; k++) begin
            if (k == 0) tick(1'b1, 8'h3C, 1'b0);
            else tick(1'b0, 8'h00, 1'b0);
            checks++;
            if (tx !== exp_tx() || busy !== exp_busy() || overrun !== m_ovr) begin
                errors++;
                $display("FAIL after_reset t=%0d: tx=%b busy=%b ovr=%b required %b %b %b",
                         t, tx, busy, overrun, exp_tx(), exp_busy(), m_ovr);
            end
        end
    endtask

    task automatic test_random();
        logic ld, clr;
        logic [7:0] d;
        for (int k = 0; k < 2500; k++) begin
            ld  = ($urandom_range(0, 17) == 0);
            clr = ($urandom_range(0, 40) == 0);
            d   = 8'($urandom);
            tick(ld, d, clr);
            checks++;
            if (tx !== exp_tx() || busy !== exp_busy() || overrun !== m_ovr) begin
                errors++;
                $display("FAIL random t=%0d: tx=%b busy=%b ovr=%b required %b %b %b",
                         t, tx, busy, overrun, exp_tx(), exp_busy(), m_ovr);
            end
        end
        drain("random");
    endtask

    task automatic test_stop2();
        logic [10:0] pat;
        pat   = {2'b11, 8'h80, 1'b0};
        load2 = 1'b1;
        data2 = 8'h80;
        tick(1'b0, 8'h00, 1'b0);
        load2 = 1'b0;
        checks++;
        if (tx2 !== 1'b1 || busy2 !== 1'b1) begin
            errors++;
            $display("FAIL stop2_e0: tx=%b busy=%b required 1 1", tx2, busy2);
        end
        for (int k = 1; k <= 22; k++) begin
            tick(1'b0, 8'h00, 1'b0);
            checks++;
            if (tx2 !== pat[(k-1)/2] || busy2 !== 1'b1) begin
                errors++;
                $display("FAIL stop2_bit k=%0d: tx=%b busy=%b required %b 1",
                         k, tx2, busy2, pat[(k-1)/2]);
            end
        end
        tick(1'b0, 8'h00, 1'b0);
        checks++;
        if (tx2 !== 1'b1 || busy2 !== 1'b0) begin
            errors++;
            $display("FAIL stop2_end: tx=%b busy=%b required 1 0", tx2, busy2);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_single();
        test_back_to_back();
        test_overrun();
        test_stop_edge();
        test_reset_mid();
        drain("mid");
        test_random();
        test_stop2();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
